decode_unit: RTL
================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, defining the data width of instruction, PC and immediate fields.
REQ-002 The block SHALL have parameter NREGS, default 16, defining the RV32E register count; register indices >= NREGS are illegal.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; one clock and one reset only.
REQ-005 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-006 in_valid  input  1  fetch presents an instruction.
REQ-007 in_ready  output  1  decode can accept; registered output.
REQ-008 in_inst  input  32  raw instruction word.
REQ-009 in_pc  input  32  PC of in_inst.
REQ-010 out_valid  output  1  decoded record valid toward execute.
REQ-011 out_ready  input  1  execute accepts the record.
REQ-012 out_pc  output  32  PC, passed through unchanged.
REQ-013 out_class  output  4  LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OP_IMM=7, OP=8, FENCE=9, SYSTEM=10, ILLEGAL=15.
REQ-014 out_rd, out_rs1, out_rs2  output  4 each  register indices (low 4 bits of the fields).
REQ-015 out_funct3  output  3; out_alt  output  1 (inst[30]); out_imm  output  32, sign-extended immediate.

Function
REQ-016 Decode SHALL be computed combinationally from in_inst and captured into an output register; latency in_valid&&in_ready to out_valid is exactly 1 cycle when the output register is free.
REQ-017 Immediates SHALL follow the RV32 I/S/B/U/J formats, sign-extended from inst[31]; U has low 12 bits zero; B and J have bit 0 zero; R-type and FENCE produce imm=0.
REQ-018 ILLEGAL SHALL be flagged for: inst[1:0]!=2'b11; unlisted opcode; any used rd/rs1/rs2 field with bit 4 set; LOAD funct3 in {3,6,7}; STORE funct3 >2; BRANCH funct3 in {2,3}; JALR funct3!=0; OP funct7 not 0x00/0x20, or 0x20 with funct3 not 0/5; OP_IMM funct3=1 with funct7!=0, or funct3=5 with funct7 not 0x00/0x20.
REQ-019 An ILLEGAL record SHALL still be delivered in order with its PC; unused register fields SHALL read 0.
REQ-020 The output SHALL be a two-entry skid buffer: output register (main) plus one skid register; no beat lost or duplicated, order preserved.
REQ-021 in_ready SHALL equal NOT skid_valid as registered state; an accept occurs only when in_valid && in_ready.
REQ-022 Main empty or out_ready high: main loads from skid if skid_valid, else from the accepted beat; otherwise main holds.
REQ-023 Main full, out_ready low, beat accepted: beat goes to skid; in_ready drops the next cycle.
REQ-024 Skid drain: when out_ready high with skid_valid, skid moves to main; a same-cycle accepted beat SHALL move into skid.
REQ-025 Outputs SHALL be stable while out_valid && !out_ready.
REQ-026 flush SHALL clear main and skid valid next cycle, drop any same-cycle accepted beat, and set in_ready=1; flush overrides out_ready.
REQ-027 Sustained in_valid and out_ready SHALL yield one record per cycle.

Reset
REQ-028 On reset: out_valid=0, skid_valid=0, in_ready=1, all data outputs 0, out_class=0.
REQ-029 Reset SHALL dominate flush and any handshake in the same cycle; entries held mid-operation are discarded.
REQ-030 First accept SHALL be possible on the first cycle after reset deasserts.

Verification
REQ-031 Reset -> out_valid=0, in_ready=1, out_imm=0 on the first post-reset cycle.
REQ-032 in_inst=0xFFF00093 (addi x1,x0,-1), PC 0x100, out_ready=1 -> next cycle out_class=7, rd=1, rs1=0, imm=0xFFFFFFFF, pc=0x100.
REQ-033 in_inst=0x01000093 (addi x1,x0,16) then 0x00000893 (rd=x17) -> first OP_IMM, second ILLEGAL with pc intact.
REQ-034 Three back-to-back beats with out_ready=0 -> two held, in_ready=0 after the second; out_ready=1 -> all three emerge in order, none lost.
REQ-035 Two beats held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; no held or same-cycle beat appears later.
REQ-036 in_inst=0xFE000EE3 (beq x0,x0,-4) -> BRANCH, imm=0xFFFFFFFC; in_inst=0x00000000 -> ILLEGAL.

Source files
------------

// File: rtl/decode_unit.sv
// RV32E decode stage: decodes a fetched instruction into a class/register/immediate record.
// Latency: one cycle from accept to out_valid when the output register is free.
// Backpressure: two-entry skid buffer; in_ready is registered and drops once the skid entry fills.
module decode_unit #(
  parameter int XLEN  = 32,
  parameter int NREGS = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [3:0]      out_class,
  output logic [3:0]      out_rd,
  output logic [3:0]      out_rs1,
  output logic [3:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic            out_alt,
  output logic [XLEN-1:0] out_imm
);

  localparam logic [3:0] CLS_LUI     = 4'd0;
  localparam logic [3:0] CLS_AUIPC   = 4'd1;
  localparam logic [3:0] CLS_JAL     = 4'd2;
  localparam logic [3:0] CLS_JALR    = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_LOAD    = 4'd5;
  localparam logic [3:0] CLS_STORE   = 4'd6;
  localparam logic [3:0] CLS_OP_IMM  = 4'd7;
  localparam logic [3:0] CLS_OP      = 4'd8;
  localparam logic [3:0] CLS_FENCE   = 4'd9;
  localparam logic [3:0] CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [3:0]      rd;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] imm;
  } rec_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_inst[6:0];
  assign rd_f   = in_inst[11:7];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  logic [3:0]  cls;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        bad;
  logic [31:0] imm32;
  rec_t        dec;

  // Classify the opcode, pick the immediate format and flag illegal encodings
  always_comb begin
    cls     = CLS_ILLEGAL;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    bad     = 1'b0;
    case (opcode)
      7'b0110111: begin
        cls    = CLS_LUI;
        use_rd = 1'b1;
        imm32  = {in_inst[31:12], 12'b0};
      end
      7'b0010111: begin
        cls    = CLS_AUIPC;
        use_rd = 1'b1;
        imm32  = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        cls    = CLS_JAL;
        use_rd = 1'b1;
        imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        cls     = CLS_JALR;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        if (funct3 != 3'd0) bad = 1'b1;
      end
      7'b1100011: begin
        cls     = CLS_BRANCH;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        if (funct3 == 3'd2 || funct3 == 3'd3) bad = 1'b1;
      end
      7'b0000011: begin
        cls     = CLS_LOAD;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) bad = 1'b1;
      end
      7'b0100011: begin
        cls     = CLS_STORE;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        if (funct3 > 3'd2) bad = 1'b1;
      end
      7'b0010011: begin
        cls     = CLS_OP_IMM;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        if (funct3 == 3'd1 && funct7 != 7'h00) bad = 1'b1;
        if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) bad = 1'b1;
      end
      7'b0110011: begin
        cls     = CLS_OP;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (funct7 != 7'h00 && funct7 != 7'h20) bad = 1'b1;
        if (funct7 == 7'h20 && funct3 != 3'd0 && funct3 != 3'd5) bad = 1'b1;
      end
      7'b0001111: begin
        cls = CLS_FENCE;
      end
      7'b1110011: begin
        cls     = CLS_SYSTEM;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      default: begin
        cls = CLS_ILLEGAL;
      end
    endcase
    if (cls == CLS_ILLEGAL) bad = 1'b1;
    if (in_inst[1:0] != 2'b11) bad = 1'b1;
    // RV32E only has NREGS architectural registers
    if (use_rd  && 32'(rd_f)  >= NREGS) bad = 1'b1;
    if (use_rs1 && 32'(rs1_f) >= NREGS) bad = 1'b1;
    if (use_rs2 && 32'(rs2_f) >= NREGS) bad = 1'b1;
  end

  // Assemble the record; illegal records keep PC/funct3/alt but zero registers and immediate
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.funct3 = funct3;
    dec.alt    = in_inst[30];
    dec.cls    = bad ? CLS_ILLEGAL : cls;
    dec.rd     = (!bad && use_rd)  ? rd_f[3:0]  : 4'd0;
    dec.rs1    = (!bad && use_rs1) ? rs1_f[3:0] : 4'd0;
    dec.rs2    = (!bad && use_rs2) ? rs2_f[3:0] : 4'd0;
    dec.imm    = bad ? '0 : XLEN'($signed(imm32));
  end

  // Skid buffer state
  rec_t main_q, main_d;
  rec_t skid_q, skid_d;
  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q;
  logic accept;
  logic main_free;

  assign accept    = in_valid && in_ready_q;
  assign main_free = !main_valid_q || out_ready;

  // Next-state for main/skid: skid always drains ahead of the incoming beat to keep order
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // Register update; reset wins over flush and any handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = main_valid_q;
  assign out_pc     = main_q.pc;
  assign out_class  = main_q.cls;
  assign out_rd     = main_q.rd;
  assign out_rs1    = main_q.rs1;
  assign out_rs2    = main_q.rs2;
  assign out_funct3 = main_q.funct3;
  assign out_alt    = main_q.alt;
  assign out_imm    = main_q.imm;

endmodule
